// File: rtl/bilinear_engine.sv
// bilinear_engine: bilinear resampler sitting behind the pixel RAM.
// Reads a DATA_WIDTH-bit greyscale source image through the RAM read port
// and writes each interpolated destination pixel through the write port.
// Steps through the source with Q(DIM).(FRAC) accumulators, one pixel per
// 7+RAM_LAT cycles.
//
// Ports:
//   clk, reset_n            clock, asynchronous active-low reset
//   start, abort            start pulse (IDLE only), synchronous abort
//   src_base, dst_base      image base addresses (latched on start)
//   src_w/h, dst_w/h        image dimensions (latched on start)
//   step_x, step_y          source step per destination pixel (latched)
//   rd_addr, rd_q           RAM read port (rd_q valid RAM_LAT cycles later)
//   wr_addr, wr_data, wr_en RAM write port
//   busy, done, err         status; err is sticky until the next start
//   pix_count               destination pixels written this/last run
//
// Optional macro BILINEAR_ROUND_EN: round half-up instead of truncating.
module bilinear_engine #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned DIM_WIDTH  = 8,
  parameter int unsigned FRAC_BITS  = 8,
  parameter int unsigned RAM_LAT    = 2
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           start,
  input  logic                           abort,
  input  logic [ADDR_WIDTH-1:0]          src_base,
  input  logic [ADDR_WIDTH-1:0]          dst_base,
  input  logic [DIM_WIDTH-1:0]           src_w,
  input  logic [DIM_WIDTH-1:0]           src_h,
  input  logic [DIM_WIDTH-1:0]           dst_w,
  input  logic [DIM_WIDTH-1:0]           dst_h,
  input  logic [DIM_WIDTH+FRAC_BITS-1:0] step_x,
  input  logic [DIM_WIDTH+FRAC_BITS-1:0] step_y,
  output logic [ADDR_WIDTH-1:0]          rd_addr,
  input  logic [DATA_WIDTH-1:0]          rd_q,
  output logic [ADDR_WIDTH-1:0]          wr_addr,
  output logic [DATA_WIDTH-1:0]          wr_data,
  output logic                           wr_en,
  output logic                           busy,
  output logic                           done,
  output logic                           err,
  output logic [2*DIM_WIDTH-1:0]         pix_count
);

  localparam int unsigned STEP_W = DIM_WIDTH + FRAC_BITS;
  localparam int unsigned XW     = 2 * DIM_WIDTH;
  localparam int unsigned FXW    = XW + FRAC_BITS;
  localparam int unsigned IW     = DATA_WIDTH + 2 * FRAC_BITS + 2;
  localparam int unsigned WCW    = (RAM_LAT > 1) ? $clog2(RAM_LAT) : 1;

  localparam logic [FRAC_BITS:0]    ONE_F = {1'b1, {FRAC_BITS{1'b0}}};
  localparam logic [DATA_WIDTH-1:0] DMAX  = {DATA_WIDTH{1'b1}};

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_CALC   = 3'd1;
  localparam logic [2:0] S_FETCH  = 3'd2;
  localparam logic [2:0] S_WAIT   = 3'd3;
  localparam logic [2:0] S_INTERP = 3'd4;
  localparam logic [2:0] S_WRITE  = 3'd5;
  localparam logic [2:0] S_DONE   = 3'd6;

  logic [2:0] state_q, state_nxt;

  // latched configuration
  logic [ADDR_WIDTH-1:0] src_base_q, dst_base_q;
  logic [DIM_WIDTH-1:0]  src_w_q, src_h_q, dst_w_q, dst_h_q;
  logic [STEP_W-1:0]     step_x_q, step_y_q;

  // position / sampling state
  logic [FXW-1:0]        fx_q, fy_q;
  logic [DIM_WIDTH-1:0]  dx_q, dy_q;
  logic [DIM_WIDTH-1:0]  x0_q, x1_q, y0_q, y1_q;
  logic [FRAC_BITS-1:0]  a_q, b_q;
  logic [1:0]            fetch_cnt_q;
  logic [WCW-1:0]        wait_cnt_q;
  logic [RAM_LAT:0]      tag_v_q;
  logic [1:0]            tag_i_q [0:RAM_LAT];
  logic [DATA_WIDTH-1:0] samp_q  [0:3];

  logic zero_in, start_ok, kill, last_pix, dx_last;
  assign zero_in  = (src_w == '0) || (src_h == '0) || (dst_w == '0) || (dst_h == '0);
  assign start_ok = (state_q == S_IDLE) && start && !abort;
  assign kill     = abort && (state_q != S_IDLE);
  assign dx_last  = (dx_q == dst_w_q - DIM_WIDTH'(1));
  assign last_pix = dx_last && (dy_q == dst_h_q - DIM_WIDTH'(1));

  // state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_nxt;
  end

  // next-state logic
  always_comb begin
    state_nxt = state_q;
    if (kill) begin
      state_nxt = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:   if (start && !abort) state_nxt = zero_in ? S_DONE : S_CALC;
        S_CALC:   state_nxt = S_FETCH;
        S_FETCH:  if (fetch_cnt_q == 2'd3) state_nxt = S_WAIT;
        S_WAIT:   if (wait_cnt_q == WCW'(RAM_LAT - 1)) state_nxt = S_INTERP;
        S_INTERP: state_nxt = S_WRITE;
        S_WRITE:  state_nxt = last_pix ? S_DONE : S_CALC;
        S_DONE:   state_nxt = S_IDLE;
        default:  state_nxt = S_IDLE;
      endcase
    end
  end

  // integer/fraction split with edge clamping for the current position
  logic [XW-1:0]        x0_raw, y0_raw;
  logic [DIM_WIDTH-1:0] src_w_m1, src_h_m1;
  logic [DIM_WIDTH-1:0] c_x0, c_x1, c_y0, c_y1;
  logic [FRAC_BITS-1:0] c_a, c_b;

  assign x0_raw   = fx_q[FXW-1:FRAC_BITS];
  assign y0_raw   = fy_q[FXW-1:FRAC_BITS];
  assign src_w_m1 = src_w_q - DIM_WIDTH'(1);
  assign src_h_m1 = src_h_q - DIM_WIDTH'(1);

  always_comb begin
    c_x0 = DIM_WIDTH'(x0_raw);
    c_a  = fx_q[FRAC_BITS-1:0];
    if (x0_raw > XW'(src_w_m1)) begin
      c_x0 = src_w_m1;
      c_a  = '0;
    end
    c_y0 = DIM_WIDTH'(y0_raw);
    c_b  = fy_q[FRAC_BITS-1:0];
    if (y0_raw > XW'(src_h_m1)) begin
      c_y0 = src_h_m1;
      c_b  = '0;
    end
    c_x1 = (c_x0 == src_w_m1) ? c_x0 : c_x0 + DIM_WIDTH'(1);
    c_y1 = (c_y0 == src_h_m1) ? c_y0 : c_y0 + DIM_WIDTH'(1);
  end

  // next read address: p00 straight out of CALC, then p01, p10, p11
  logic [DIM_WIDTH-1:0]  ax, ay;
  logic [ADDR_WIDTH-1:0] rd_addr_nxt;
  logic [1:0]            issue_idx;

  always_comb begin
    ax        = c_x0;
    ay        = c_y0;
    issue_idx = 2'd0;
    if (state_q != S_CALC) begin
      issue_idx = fetch_cnt_q + 2'd1;
      case (fetch_cnt_q)
        2'd0:    begin ax = x1_q; ay = y0_q; end
        2'd1:    begin ax = x0_q; ay = y1_q; end
        default: begin ax = x1_q; ay = y1_q; end
      endcase
    end
  end

  assign rd_addr_nxt = src_base_q + ADDR_WIDTH'(XW'(ay) * XW'(src_w_q)) + ADDR_WIDTH'(ax);

  // bilinear blend of the four captured samples
  logic [FRAC_BITS:0]    wa, wb;
  logic [IW-1:0]         t_row, u_row, s_sum, s_rnd, r_full;
  logic [DATA_WIDTH-1:0] r_pix;

  always_comb begin
    wa    = ONE_F - {1'b0, a_q};
    wb    = ONE_F - {1'b0, b_q};
    t_row = IW'(samp_q[0]) * IW'(wa) + IW'(samp_q[1]) * IW'(a_q);
    u_row = IW'(samp_q[2]) * IW'(wa) + IW'(samp_q[3]) * IW'(a_q);
    s_sum = t_row * IW'(wb) + u_row * IW'(b_q);
`ifdef BILINEAR_ROUND_EN
    s_rnd = s_sum + (IW'(1) << (2 * FRAC_BITS - 1));
`else
    s_rnd = s_sum;
`endif
    r_full = s_rnd >> (2 * FRAC_BITS);
    r_pix  = (r_full > IW'(DMAX)) ? DMAX : DATA_WIDTH'(r_full);
  end

  // configuration latch, position accumulators and per-pixel counters
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      src_base_q  <= '0;
      dst_base_q  <= '0;
      src_w_q     <= '0;
      src_h_q     <= '0;
      dst_w_q     <= '0;
      dst_h_q     <= '0;
      step_x_q    <= '0;
      step_y_q    <= '0;
      fx_q        <= '0;
      fy_q        <= '0;
      dx_q        <= '0;
      dy_q        <= '0;
      x0_q        <= '0;
      x1_q        <= '0;
      y0_q        <= '0;
      y1_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      fetch_cnt_q <= '0;
      wait_cnt_q  <= '0;
    end else begin
      if (start_ok) begin
        src_base_q <= src_base;
        dst_base_q <= dst_base;
        src_w_q    <= src_w;
        src_h_q    <= src_h;
        dst_w_q    <= dst_w;
        dst_h_q    <= dst_h;
        step_x_q   <= step_x;
        step_y_q   <= step_y;
        fx_q       <= '0;
        fy_q       <= '0;
        dx_q       <= '0;
        dy_q       <= '0;
      end
      if (state_q == S_CALC) begin
        x0_q        <= c_x0;
        x1_q        <= c_x1;
        y0_q        <= c_y0;
        y1_q        <= c_y1;
        a_q         <= c_a;
        b_q         <= c_b;
        fetch_cnt_q <= '0;
      end
      if (state_q == S_FETCH) begin
        fetch_cnt_q <= fetch_cnt_q + 2'd1;
        wait_cnt_q  <= '0;
      end
      if (state_q == S_WAIT) wait_cnt_q <= wait_cnt_q + WCW'(1);
      // raster advance: the x accumulator restarts at each new row
      if (state_q == S_WRITE) begin
        if (dx_last) begin
          dx_q <= '0;
          dy_q <= dy_q + DIM_WIDTH'(1);
          fx_q <= '0;
          fy_q <= fy_q + FXW'(step_y_q);
        end else begin
          dx_q <= dx_q + DIM_WIDTH'(1);
          fx_q <= fx_q + FXW'(step_x_q);
        end
      end
    end
  end

  // read tag pipeline: a sample lands RAM_LAT cycles after its address
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tag_v_q <= '0;
      for (int unsigned i = 0; i <= RAM_LAT; i++) tag_i_q[i] <= '0;
      for (int unsigned k = 0; k < 4; k++) samp_q[k] <= '0;
    end else begin
      tag_v_q[0] <= (state_nxt == S_FETCH);
      tag_i_q[0] <= issue_idx;
      for (int unsigned i = 1; i <= RAM_LAT; i++) begin
        tag_v_q[i] <= tag_v_q[i-1] && !kill;
        tag_i_q[i] <= tag_i_q[i-1];
      end
      if (tag_v_q[RAM_LAT] && !kill) samp_q[tag_i_q[RAM_LAT]] <= rd_q;
    end
  end

  // registered outputs, aligned with the state they belong to
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_addr   <= '0;
      wr_addr   <= '0;
      wr_data   <= '0;
      wr_en     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      pix_count <= '0;
    end else begin
      busy  <= (state_nxt != S_IDLE);
      done  <= (state_q == S_DONE) && !abort;
      wr_en <= (state_nxt == S_WRITE);
      if (start_ok) begin
        err       <= zero_in;
        pix_count <= '0;
      end
      if (state_nxt == S_FETCH) rd_addr <= rd_addr_nxt;
      if (state_nxt == S_WRITE) begin
        wr_addr   <= dst_base_q + ADDR_WIDTH'(XW'(dy_q) * XW'(dst_w_q)) + ADDR_WIDTH'(dx_q);
        wr_data   <= r_pix;
        pix_count <= pix_count + XW'(1);
      end
    end
  end

endmodule

// File: tb/tb_bilinear_engine.sv
// tb_bilinear_engine: directed bench for bilinear_engine with a RAM_LAT=2
// behavioural RAM and hand-computed expected pixels and latencies.
module tb_bilinear_engine;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start, abort;
  logic [15:0] src_base, dst_base;
  logic [7:0]  src_w, src_h, dst_w, dst_h;
  logic [15:0] step_x, step_y;
  logic [15:0] rd_addr, wr_addr;
  logic [7:0]  rd_q, wr_data;
  logic        wr_en, busy, done, err;
  logic [15:0] pix_count;

  bilinear_engine dut (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
    .src_base(src_base), .dst_base(dst_base),
    .src_w(src_w), .src_h(src_h), .dst_w(dst_w), .dst_h(dst_h),
    .step_x(step_x), .step_y(step_y),
    .rd_addr(rd_addr), .rd_q(rd_q),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_en(wr_en),
    .busy(busy), .done(done), .err(err), .pix_count(pix_count)
  );

  always #5 clk = ~clk;

  // source RAM (read-only to the DUT), written only by the stimulus block
  logic [7:0]  mem     [0:65535];
  logic [7:0]  out_mem [0:65535];
  logic        wflag   [0:65535];
  logic [15:0] ram_d1;
  int          cyc = 0;
  int          wr_cnt = 0, done_cnt = 0, done_cyc = 0;
  int          hit_cyc [0:3];
  int          total = 0, bad = 0;

  // two-stage read pipeline: data for rd_addr arrives two cycles later
  always @(posedge clk) begin
    cyc    <= cyc + 1;
    ram_d1 <= rd_addr;
    rd_q   <= mem[ram_d1];
  end

  // write capture and event log, sampled mid-cycle
  always @(negedge clk) begin
    if (wr_en) begin
      out_mem[wr_addr] <= wr_data;
      wflag[wr_addr]   <= 1'b1;
      wr_cnt           <= wr_cnt + 1;
    end
    if (done) begin
      done_cnt <= done_cnt + 1;
      done_cyc <= cyc;
    end
    if (busy) begin
      if (rd_addr == 16'hFFFE) hit_cyc[0] <= cyc;
      if (rd_addr == 16'hFFFF) hit_cyc[1] <= cyc;
      if (rd_addr == 16'h0000) hit_cyc[2] <= cyc;
      if (rd_addr == 16'h0001) hit_cyc[3] <= cyc;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cfg(input logic [15:0] sb, input logic [15:0] db,
                         input logic [7:0] sw, input logic [7:0] sh,
                         input logic [7:0] dw, input logic [7:0] dh,
                         input logic [15:0] stx, input logic [15:0] sty);
    src_base = sb; dst_base = db;
    src_w = sw; src_h = sh; dst_w = dw; dst_h = dh;
    step_x = stx; step_y = sty;
  endtask

  // start a run, optionally re-pulse start mid-run with a changed dst_base,
  // and wait (bounded) for done; returns latency, write count and start cycle
  task automatic run(input int budget, input int mid, output int lat, output int nwr, output int s);
    int wb, db;
    wb = wr_cnt; db = done_cnt; s = cyc;
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 1; i < budget; i++) begin
      if (done_cnt != db) break;
      if (mid != 0 && i == mid) begin
        dst_base = 16'h0500;
        start    = 1'b1;
      end
      tick();
      start = 1'b0;
    end
    chk("done_seen", done_cnt - db, 1);
    lat = done_cyc - s;
    nwr = wr_cnt - wb;
  endtask

  int lat, nwr, s, wb, db;
  logic [15:0] exp_v;

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'd0;
    for (int i = 0; i < 16; i++) mem[i] = 8'(i);
    mem[16'h0010] = 8'd0;   mem[16'h0011] = 8'd100;
    mem[16'h0012] = 8'd200; mem[16'h0013] = 8'd255;
    mem[16'hFFFE] = 8'h5A;  mem[16'hFFFF] = 8'hA5;
    for (int k = 0; k < 4; k++) hit_cyc[k] = 0;
    reset_n = 1'b0; start = 1'b0; abort = 1'b0;
    set_cfg(16'h0, 16'h0, 8'd0, 8'd0, 8'd0, 8'd0, 16'd0, 16'd0);
    repeat (3) tick();

    // reset state
    chk("rst_rd_addr", rd_addr, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_pix_count", pix_count, 0);
    reset_n = 1'b1;
    tick();

    // identity copy; second start mid-run with a new dst_base is ignored
    set_cfg(16'h0000, 16'h0100, 8'd4, 8'd4, 8'd4, 8'd4, 16'd256, 16'd256);
    run(400, 20, lat, nwr, s);
    chk("id_latency", lat, 16 * 9 + 2);
    chk("id_writes", nwr, 16);
    chk("id_pix_count", pix_count, 16);
    chk("id_busy_after", busy, 0);
    chk("id_ignored_start", wflag[16'h0500], 0);
    for (int i = 0; i < 16; i++) chk($sformatf("id_px%0d", i), out_mem[16'h0100 + i], i);

    // 2x2 -> 4x4 upscale at half-pixel steps
    set_cfg(16'h0010, 16'h0300, 8'd2, 8'd2, 8'd4, 8'd4, 16'd128, 16'd128);
    run(400, 0, lat, nwr, s);
    chk("up_writes", nwr, 16);
    chk("up_px00", out_mem[16'h0300], 0);
    chk("up_px10", out_mem[16'h0301], 50);
    chk("up_px20", out_mem[16'h0302], 100);
    chk("up_px30_xclamp", out_mem[16'h0303], 100);
    chk("up_px03_yclamp", out_mem[16'h030C], 200);
`ifdef BILINEAR_ROUND_EN
    chk("up_px11", out_mem[16'h0305], 139);
`else
    chk("up_px11", out_mem[16'h0305], 138);
`endif

    // zero dimension
    set_cfg(16'h0000, 16'h0400, 8'd4, 8'd4, 8'd0, 8'd4, 16'd256, 16'd256);
    run(20, 0, lat, nwr, s);
    chk("zd_latency", lat, 2);
    chk("zd_err", err, 1);
    chk("zd_writes", nwr, 0);
    chk("zd_pix_count", pix_count, 0);

    // address wrap at the top of memory; also clears err
    set_cfg(16'hFFFE, 16'h0200, 8'd2, 8'd2, 8'd2, 8'd2, 16'd256, 16'd256);
    run(100, 0, lat, nwr, s);
    chk("wr_err_cleared", err, 0);
    chk("wr_latency", lat, 4 * 9 + 2);
    chk("wr_hit_fffe", (hit_cyc[0] > s) ? 1 : 0, 1);
    chk("wr_hit_ffff", (hit_cyc[1] > s) ? 1 : 0, 1);
    chk("wr_hit_0000", (hit_cyc[2] > s) ? 1 : 0, 1);
    chk("wr_hit_0001", (hit_cyc[3] > s) ? 1 : 0, 1);
    chk("wr_px0", out_mem[16'h0200], 8'h5A);
    chk("wr_px1", out_mem[16'h0201], 8'hA5);
    chk("wr_px2", out_mem[16'h0202], 0);
    chk("wr_px3", out_mem[16'h0203], 1);

    // abort during the first WAIT cycle of the sixth pixel
    set_cfg(16'h0000, 16'h0100, 8'd4, 8'd4, 8'd4, 8'd4, 16'd256, 16'd256);
    wb = wr_cnt; db = done_cnt;
    start = 1'b1; tick(); start = 1'b0;
    repeat (50) tick();
    abort = 1'b1; tick(); abort = 1'b0;
    chk("ab_busy", busy, 0);
    chk("ab_wr_en", wr_en, 0);
    repeat (20) tick();
    chk("ab_writes", wr_cnt - wb, 5);
    chk("ab_no_done", done_cnt - db, 0);
    chk("ab_pix_count", pix_count, 5);
    run(400, 0, lat, nwr, s);
    chk("ab_restart_latency", lat, 16 * 9 + 2);
    chk("ab_restart_writes", nwr, 16);

    // reset asserted while a write is on the port
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (wr_en) break;
      tick();
    end
    chk("mr_saw_write", wr_en, 1);
    reset_n = 1'b0;
    #1;
    chk("mr_wr_en", wr_en, 0);
    chk("mr_busy", busy, 0);
    chk("mr_rd_addr", rd_addr, 0);
    chk("mr_wr_addr", wr_addr, 0);
    chk("mr_wr_data", wr_data, 0);
    chk("mr_pix_count", pix_count, 0);
    tick();
    reset_n = 1'b1;
    tick();
    set_cfg(16'hFFFE, 16'h0600, 8'd2, 8'd2, 8'd2, 8'd2, 16'd256, 16'd256);
    run(100, 0, lat, nwr, s);
    chk("mr_after_latency", lat, 4 * 9 + 2);
    chk("mr_after_px1", out_mem[16'h0601], 8'hA5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
